// File: rtl/pointwise_affine_controller_if.sv
// Handshake bundle between an iteration-domain controller and its unified buffer port.
// The controller is the master: it drives the port enable and loop indices.
interface pointwise_affine_controller_if;
    logic        flush;
    logic        stall;
    logic        en;
    logic [15:0] ctrl_vars [3];
    logic        busy;
    logic        done;

    modport master (
        input  flush,
        input  stall,
        output en,
        output ctrl_vars,
        output busy,
        output done
    );

    modport slave (
        output flush,
        output stall,
        input  en,
        input  ctrl_vars,
        input  busy,
        input  done
    );
endinterface

// File: rtl/pointwise_affine_controller.sv
// Schedule-driven controller for one compute op: walks the loop nest {d0, d2, d1}
// at a fixed initiation interval, starting a fixed delay after flush, and drives
// a buffer port enable plus its ctrl_vars index vector.
module pointwise_affine_controller #(
    parameter int EXT0        = 1,
    parameter int EXT2        = 64,
    parameter int EXT1        = 64,
    parameter int START_CYCLE = 0,
    parameter int II          = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    pointwise_affine_controller_if.master   bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RUN, DONE} state_t;

    localparam logic [15:0] MAX0       = 16'(EXT0 - 1);
    localparam logic [15:0] MAX1       = 16'(EXT1 - 1);
    localparam logic [15:0] MAX2       = 16'(EXT2 - 1);
    localparam logic [15:0] START_LOAD = 16'(START_CYCLE - 1);
    localparam logic [7:0]  II_LAST    = 8'(II - 1);

    state_t      state, state_nxt;
    logic [15:0] d0, d1, d2;
    logic [15:0] d0_nxt, d1_nxt, d2_nxt;
    logic [15:0] start_cnt, start_nxt;
    logic [7:0]  ii_cnt, ii_nxt;
    logic        busy, busy_nxt;
    logic        done, done_nxt;
    logic        issue;
    logic        last;

    // en is the only combinational output so that stall masks it in the same cycle
    assign issue = (state == RUN) && (ii_cnt == '0) && !bus.stall;
    assign last  = (d0 == MAX0) && (d1 == MAX1) && (d2 == MAX2);

    assign bus.en           = issue;
    assign bus.ctrl_vars[0] = d0;
    assign bus.ctrl_vars[1] = d1;
    assign bus.ctrl_vars[2] = d2;
    assign bus.busy         = busy;
    assign bus.done         = done;

    // State and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            d0        <= '0;
            d1        <= '0;
            d2        <= '0;
            start_cnt <= '0;
            ii_cnt    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            d0        <= d0_nxt;
            d1        <= d1_nxt;
            d2        <= d2_nxt;
            start_cnt <= start_nxt;
            ii_cnt    <= ii_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state logic: flush restarts from any state, stall freezes everything else
    always_comb begin
        state_nxt = state;
        d0_nxt    = d0;
        d1_nxt    = d1;
        d2_nxt    = d2;
        start_nxt = start_cnt;
        ii_nxt    = ii_cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        if (bus.flush) begin
            if (START_CYCLE > 0) begin
                state_nxt = WAIT;
            end else begin
                state_nxt = RUN;
            end
            d0_nxt    = '0;
            d1_nxt    = '0;
            d2_nxt    = '0;
            ii_nxt    = '0;
            start_nxt = START_LOAD;
            busy_nxt  = 1'b1;
        end else if (!bus.stall) begin
            unique case (state)
                WAIT: begin
                    if (start_cnt == '0) begin
                        state_nxt = RUN;
                    end else begin
                        start_nxt = start_cnt - 16'd1;
                    end
                end
                RUN: begin
                    ii_nxt = (ii_cnt == II_LAST) ? '0 : ii_cnt + 8'd1;
                    if (issue) begin
                        // final iteration leaves the indices at their maxima
                        if (last) begin
                            state_nxt = DONE;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else if (d1 != MAX1) begin
                            d1_nxt = d1 + 16'd1;
                        end else begin
                            d1_nxt = '0;
                            if (d2 != MAX2) begin
                                d2_nxt = d2 + 16'd1;
                            end else begin
                                d2_nxt = '0;
                                d0_nxt = d0 + 16'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pointwise_affine_controller.sv
// Directed bench for pointwise_affine_controller: three parameterisations driven
// by scenario tasks, each comparing outputs against hand-derived expectations.
module tb_pointwise_affine_controller;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    pointwise_affine_controller_if b0 ();
    pointwise_affine_controller_if b1 ();
    pointwise_affine_controller_if b2 ();

    pointwise_affine_controller #(
        .EXT0(1), .EXT2(64), .EXT1(64), .START_CYCLE(0), .II(1)
    ) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    pointwise_affine_controller #(
        .EXT0(1), .EXT2(64), .EXT1(64), .START_CYCLE(5), .II(3)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    pointwise_affine_controller #(
        .EXT0(2), .EXT2(3), .EXT1(4), .START_CYCLE(0), .II(1)
    ) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {d0, d1, d2} for 0-based iteration k of a nest with inner extents e1 (col), e2 (row)
    function automatic logic [47:0] idx(input int k, input int e1, input int e2);
        return {16'(k / (e1 * e2)), 16'(k % e1), 16'((k / e1) % e2)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        b0.flush = 1'b0; b0.stall = 1'b0;
        b1.flush = 1'b0; b1.stall = 1'b0;
        b2.flush = 1'b0; b2.stall = 1'b0;
        #2;
        n_cmp++;
        if ({b0.en, b0.busy, b0.done} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags got=%b want=000", {b0.en, b0.busy, b0.done});
        end
        n_cmp++;
        if ({b0.ctrl_vars[0], b0.ctrl_vars[1], b0.ctrl_vars[2]} !== 48'h0) begin
            n_bad++; $display("FAIL reset_ctrl got=%h want=0", {b0.ctrl_vars[0], b0.ctrl_vars[1], b0.ctrl_vars[2]});
        end
        n_cmp++;
        if ({b1.en, b1.busy, b1.done, b2.en, b2.busy, b2.done} !== 6'b0) begin
            n_bad++; $display("FAIL reset_others got=%b want=000000", {b1.en, b1.busy, b1.done, b2.en, b2.busy, b2.done});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_default_run();
        logic        exp_en;
        logic [47:0] got;
        @(negedge clk);
        b0.flush = 1'b1;
        for (int c = 1; c <= 4098; c++) begin
            @(negedge clk);
            b0.flush = 1'b0;
            #1;
            exp_en = (c <= 4096);
            got = {b0.ctrl_vars[0], b0.ctrl_vars[1], b0.ctrl_vars[2]};
            n_cmp++;
            if (b0.en !== exp_en) begin
                n_bad++; $display("FAIL dflt_en c=%0d got=%b want=%b", c, b0.en, exp_en);
            end
            n_cmp++;
            if (b0.busy !== exp_en) begin
                n_bad++; $display("FAIL dflt_busy c=%0d got=%b want=%b", c, b0.busy, exp_en);
            end
            n_cmp++;
            if (b0.done !== (c == 4097)) begin
                n_bad++; $display("FAIL dflt_done c=%0d got=%b want=%b", c, b0.done, (c == 4097));
            end
            if (exp_en) begin
                n_cmp++;
                if (got !== idx(c - 1, 64, 64)) begin
                    n_bad++; $display("FAIL dflt_ctrl c=%0d got=%h want=%h", c, got, idx(c - 1, 64, 64));
                end
            end
            if (c == 1 || c == 2 || c == 65 || c == 4096 || c == 4097) begin
                n_cmp++;
                if (got !== ((c == 1)  ? 48'h0000_0000_0000 :
                             (c == 2)  ? 48'h0000_0001_0000 :
                             (c == 65) ? 48'h0000_0000_0001 : 48'h0000_003F_003F)) begin
                    n_bad++; $display("FAIL dflt_spot c=%0d got=%h", c, got);
                end
            end
        end
    endtask

    task automatic test_start_ii();
        logic        exp_en;
        logic [47:0] got;
        @(negedge clk);
        b1.flush = 1'b1;
        for (int c = 1; c <= 12293; c++) begin
            @(negedge clk);
            b1.flush = 1'b0;
            #1;
            exp_en = (c >= 6) && ((c - 6) % 3 == 0) && ((c - 6) / 3 < 4096);
            got = {b1.ctrl_vars[0], b1.ctrl_vars[1], b1.ctrl_vars[2]};
            n_cmp++;
            if (b1.en !== exp_en) begin
                n_bad++; $display("FAIL ii_en c=%0d got=%b want=%b", c, b1.en, exp_en);
            end
            n_cmp++;
            if (b1.busy !== (c <= 12291)) begin
                n_bad++; $display("FAIL ii_busy c=%0d got=%b want=%b", c, b1.busy, (c <= 12291));
            end
            n_cmp++;
            if (b1.done !== (c == 12292)) begin
                n_bad++; $display("FAIL ii_done c=%0d got=%b want=%b", c, b1.done, (c == 12292));
            end
            if (exp_en) begin
                n_cmp++;
                if (got !== idx((c - 6) / 3, 64, 64)) begin
                    n_bad++; $display("FAIL ii_ctrl c=%0d got=%h want=%h", c, got, idx((c - 6) / 3, 64, 64));
                end
            end
            if (c == 36) begin
                n_cmp++;
                if (got !== 48'h0000_000A_0000) begin
                    n_bad++; $display("FAIL ii_iter10 got=%h want=0000000a0000", got);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic        stl;
        logic        exp_en;
        logic [47:0] got;
        int          k;
        @(negedge clk);
        b0.flush = 1'b1;
        for (int c = 1; c <= 4102; c++) begin
            @(negedge clk);
            b0.flush = 1'b0;
            stl = (c >= 64) && (c <= 67);
            b0.stall = stl;
            #1;
            exp_en = !stl && (c <= 4100);
            k = (c < 64) ? c - 1 : c - 5;
            got = {b0.ctrl_vars[0], b0.ctrl_vars[1], b0.ctrl_vars[2]};
            n_cmp++;
            if (b0.en !== exp_en) begin
                n_bad++; $display("FAIL stall_en c=%0d got=%b want=%b", c, b0.en, exp_en);
            end
            n_cmp++;
            if (b0.busy !== (c <= 4100)) begin
                n_bad++; $display("FAIL stall_busy c=%0d got=%b want=%b", c, b0.busy, (c <= 4100));
            end
            n_cmp++;
            if (b0.done !== (c == 4101)) begin
                n_bad++; $display("FAIL stall_done c=%0d got=%b want=%b", c, b0.done, (c == 4101));
            end
            if (exp_en) begin
                n_cmp++;
                if (got !== idx(k, 64, 64)) begin
                    n_bad++; $display("FAIL stall_ctrl c=%0d got=%h want=%h", c, got, idx(k, 64, 64));
                end
            end
            if (c == 66 || c == 68 || c == 69) begin
                n_cmp++;
                if (got !== ((c == 69) ? 48'h0000_0000_0001 : 48'h0000_003F_0000)) begin
                    n_bad++; $display("FAIL stall_spot c=%0d got=%h", c, got);
                end
            end
        end
        b0.stall = 1'b0;
    endtask

    task automatic test_flush_restart();
        int          en_cnt;
        logic [47:0] got;
        @(negedge clk);
        b0.flush = 1'b1;
        for (int c = 1; c <= 101; c++) begin
            @(negedge clk);
            b0.flush = (c == 101);
            #1;
            n_cmp++;
            if (b0.en !== 1'b1) begin
                n_bad++; $display("FAIL rst1_en c=%0d got=%b want=1", c, b0.en);
            end
        end
        got = {b0.ctrl_vars[0], b0.ctrl_vars[1], b0.ctrl_vars[2]};
        n_cmp++;
        if (got !== 48'h0000_0024_0001) begin
            n_bad++; $display("FAIL rst1_iter100 got=%h want=000000240001", got);
        end
        en_cnt = 0;
        for (int c = 1; c <= 4098; c++) begin
            @(negedge clk);
            b0.flush = 1'b0;
            #1;
            if (b0.en === 1'b1) en_cnt++;
            n_cmp++;
            if (b0.done !== (c == 4097)) begin
                n_bad++; $display("FAIL rst2_done c=%0d got=%b want=%b", c, b0.done, (c == 4097));
            end
            if (c == 1) begin
                got = {b0.ctrl_vars[0], b0.ctrl_vars[1], b0.ctrl_vars[2]};
                n_cmp++;
                if ({b0.en, got} !== {1'b1, 48'h0}) begin
                    n_bad++; $display("FAIL rst2_first got=%b/%h want=1/0", b0.en, got);
                end
            end
        end
        n_cmp++;
        if (en_cnt != 4096) begin
            n_bad++; $display("FAIL rst2_count got=%0d want=4096", en_cnt);
        end
    endtask

    task automatic test_async_reset();
        int en_cnt;
        @(negedge clk);
        b0.flush = 1'b1;
        for (int c = 1; c <= 2001; c++) begin
            @(negedge clk);
            b0.flush = 1'b0;
            #1;
            n_cmp++;
            if (b0.en !== 1'b1) begin
                n_bad++; $display("FAIL arst_pre_en c=%0d got=%b want=1", c, b0.en);
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({b0.en, b0.busy, b0.done} !== 3'b000) begin
            n_bad++; $display("FAIL arst_flags got=%b want=000", {b0.en, b0.busy, b0.done});
        end
        n_cmp++;
        if ({b0.ctrl_vars[0], b0.ctrl_vars[1], b0.ctrl_vars[2]} !== 48'h0) begin
            n_bad++; $display("FAIL arst_ctrl got=%h want=0", {b0.ctrl_vars[0], b0.ctrl_vars[1], b0.ctrl_vars[2]});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            #1;
            if (b0.en !== 1'b0) en_cnt++;
            n_cmp++;
            if (b0.busy !== 1'b0) begin
                n_bad++; $display("FAIL arst_busy c=%0d got=%b want=0", c, b0.busy);
            end
        end
        n_cmp++;
        if (en_cnt != 0) begin
            n_bad++; $display("FAIL arst_noen got=%0d want=0", en_cnt);
        end
    endtask

    task automatic test_small_ext();
        logic        exp_en;
        logic [47:0] got;
        @(negedge clk);
        b2.flush = 1'b1;
        b2.stall = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            b2.flush = 1'b0;
            b2.stall = 1'b0;
            #1;
            exp_en = (c <= 24);
            got = {b2.ctrl_vars[0], b2.ctrl_vars[1], b2.ctrl_vars[2]};
            n_cmp++;
            if (b2.en !== exp_en) begin
                n_bad++; $display("FAIL small_en c=%0d got=%b want=%b", c, b2.en, exp_en);
            end
            n_cmp++;
            if (b2.done !== (c == 25)) begin
                n_bad++; $display("FAIL small_done c=%0d got=%b want=%b", c, b2.done, (c == 25));
            end
            n_cmp++;
            if (b2.busy !== exp_en) begin
                n_bad++; $display("FAIL small_busy c=%0d got=%b want=%b", c, b2.busy, exp_en);
            end
            if (exp_en) begin
                n_cmp++;
                if (got !== idx(c - 1, 4, 3)) begin
                    n_bad++; $display("FAIL small_ctrl c=%0d got=%h want=%h", c, got, idx(c - 1, 4, 3));
                end
            end
            if (c == 13 || c == 25) begin
                n_cmp++;
                if (got !== ((c == 13) ? 48'h0001_0000_0000 : 48'h0001_0003_0002)) begin
                    n_bad++; $display("FAIL small_spot c=%0d got=%h", c, got);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_default_run();
        test_start_ii();
        test_stall();
        test_flush_restart();
        test_async_reset();
        test_small_ext();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
